operand_sequencer: RTL and testbench
====================================

# operand_sequencer

Operand and multiply-step sequencer for the matrix-multiply engine. It accepts the serial operand stream while the controller is in its load phase and writes the 64 A words and then the 32 X words into the operand buffers. It raises `aload_done`/`xload_done`. During the multiply phase it owns the step counter `count_mul`, the column index and the buffer read addresses, and pulses `ALU_done` after the last step of column 3.

## Interface
- `DATA_W`, 8, operand word width
- `A_WORDS`, 64, A words per job (8 columns × 8), fixed by 6-bit write address
- `X_WORDS`, 32, X words per job (4 columns × 8), fixed by 5-bit read address
- `clk` input 1 — single clock, rising edge
- `rst` input 1 — asynchronous, active-low reset
- `start_in` input 1 — job start pulse from host (same signal the controller sees)
- `input_load_en` input 1 — controller is in load phase
- `ALU_en` input 1 — controller is in multiply phase; one multiply step per high cycle
- `in_valid` input 1 — operand word valid
- `in_data` input DATA_W — operand word
- `in_ready` output 1 — word accepted when `in_valid && in_ready`
- `wr_en` output 1 — buffer write strobe
- `wr_sel` output 1 — 0 = A buffer, 1 = X buffer
- `wr_addr` output 6 — buffer write address (X uses [4:0], [5]=0)
- `wr_data` output DATA_W — buffer write data
- `aload_done` output 1 — all A words written (sticky)
- `xload_done` output 1 — all X words written (sticky)
- `count_mul` output 3 — current multiply step k
- `col_idx` output 2 — current output column c
- `x_rd_addr` output 5 — {col_idx, count_mul}
- `a_rd_k` output 3 — equals count_mul; selects A column k (8 words read in parallel)
- `ALU_done` output 1 — one-cycle pulse, job complete

## Operation
- States: IDLE, LOAD_A, LOAD_X, WAIT_MUL, MUL.
- IDLE: on `start_in`, clear load counter, `count_mul`, `col_idx`, `aload_done`, `xload_done`; go to LOAD_A. `start_in` in any other state is ignored.
- `in_ready = input_load_en && (state==LOAD_A || state==LOAD_X)`. Words with `in_valid` while `in_ready`=0 are dropped; no back-pressure buffering.
- LOAD_A: each accepted word gives `wr_en`=1, `wr_sel`=0, `wr_addr`=load count (0..63), `wr_data`=`in_data`. These are registered and appear the cycle after acceptance. After word 63 is accepted, set `aload_done`, reset the load count, and go to LOAD_X.
- LOAD_X: same, with `wr_sel`=1, addr 0..31. After word 31 is accepted, set `xload_done` and go to WAIT_MUL.
- WAIT_MUL: first cycle with `ALU_en`=1 goes to MUL, and that cycle counts as step 0.
- MUL: each `ALU_en` cycle is one step. At the clock edge `count_mul` increments, wrapping 7→0. On wrap, `col_idx` increments. On wrap with `col_idx`==3, `col_idx` wraps to 0, `ALU_done` is set for exactly one cycle, and the state returns to IDLE. Cycles with `ALU_en`=0 (controller next_col) hold all counters.
- `ALU_en` outside WAIT_MUL/MUL and `in_valid` outside load states have no effect.
- `x_rd_addr` and `a_rd_k` are combinational from the counters and are valid in the same cycle as `count_mul`.

## Timing
- Reset (async assert, sync release): state IDLE. All outputs 0: `in_ready`, `wr_en`, `wr_sel`, `wr_addr`, `wr_data`, both done flags, `count_mul`, `col_idx`, `ALU_done`.
- Reset mid-job aborts immediately. No buffer write is issued after reset asserts.
- Done flags rise one cycle after the last word of the phase is accepted, the same cycle as that word's `wr_en`. They stay high until the next accepted `start_in`.
- Per column: 8 `ALU_en` cycles with `count_mul` = 0,1,…,7. The controller sees 7 on the 8th cycle.
- `ALU_done` is high in the cycle after the 32nd step, which is the controller's final next_col cycle. `ALU_done` is therefore coincident with the controller's `finish`.
- Minimum job time with continuous `in_valid`: 1 start + 96 load + 1 + 32 steps + 3 gap cycles.
- `start_in` in the same cycle as `ALU_done`: state is still leaving MUL, so the pulse is ignored. The host must re-issue it.

## Test plan
- Reset with `in_valid`=1 and `ALU_en`=1 → all outputs 0, state IDLE, `in_ready`=0.
- `start_in`, then 96 back-to-back words 0x00..0x5F with `input_load_en`=1 → writes A addr 0..63 with data 0x00..0x3F, then X addr 0..31 with data 0x40..0x5F. `aload_done` rises after word 63; `xload_done` rises after word 95.
- Toggle `in_valid` and `input_load_en` randomly during load → only words accepted with `in_ready`=1 are written. Write addresses have no gaps or duplicates.
- Controller-style `ALU_en` pattern (8 high, 1 low, ×4) → `x_rd_addr` sequence 0..31, `col_idx` 0,1,2,3. Single `ALU_done` pulse during the last low cycle; state returns to IDLE.
- Assert `rst` at step 13 of multiply, then start a new job → counters restart at 0. The full load and multiply completes normally.
- `start_in` during LOAD_X and during MUL → ignored. Addresses and counters are unaffected.

Source files
------------

// File: rtl/operand_sequencer_if.sv
// Operand stream and buffer write bus for the operand sequencer.
// Master drives operands and watches writes; slave is the sequencer.
interface operand_sequencer_if #(
    parameter int DATA_W = 8
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              wr_en;
    logic              wr_sel;
    logic [5:0]        wr_addr;
    logic [DATA_W-1:0] wr_data;

    modport master (
        output in_valid, in_data,
        input  in_ready, wr_en, wr_sel, wr_addr, wr_data
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, wr_en, wr_sel, wr_addr, wr_data
    );
endinterface

// File: rtl/operand_sequencer.sv
// Operand load and multiply-step sequencer for the matrix-multiply engine.
// Loads 64 A words then 32 X words, then walks 4 columns x 8 steps.
module operand_sequencer #(
    parameter int DATA_W  = 8,
    parameter int A_WORDS = 64,
    parameter int X_WORDS = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_in,
    input  logic                input_load_en,
    input  logic                ALU_en,
    operand_sequencer_if.slave  bus,
    output logic                aload_done,
    output logic                xload_done,
    output logic [2:0]          count_mul,
    output logic [1:0]          col_idx,
    output logic [4:0]          x_rd_addr,
    output logic [2:0]          a_rd_k,
    output logic                ALU_done
);

    typedef enum logic [2:0] {
        IDLE, LOAD_A, LOAD_X, WAIT_MUL, MUL
    } state_t;

    state_t     state, state_nx;
    logic [5:0] load_cnt;
    logic       rdy, accept, step;
    logic       last_a, last_x, last_step;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    // Next-state: MUL lingers through the ALU_done cycle so a start
    // pulse coincident with ALU_done is ignored
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:     if (start_in)  state_nx = LOAD_A;
            LOAD_A:   if (last_a)    state_nx = LOAD_X;
            LOAD_X:   if (last_x)    state_nx = WAIT_MUL;
            WAIT_MUL: if (step)      state_nx = MUL;
            MUL:      if (ALU_done)  state_nx = IDLE;
            default:                 state_nx = IDLE;
        endcase
    end

    // Combinational handshake and step qualifiers
    always_comb begin
        rdy       = input_load_en &&
                    (state == LOAD_A || state == LOAD_X);
        accept    = bus.in_valid && rdy;
        step      = ALU_en && (state == WAIT_MUL ||
                    (state == MUL && !ALU_done));
        last_a    = accept && state == LOAD_A &&
                    load_cnt == 6'(A_WORDS - 1);
        last_x    = accept && state == LOAD_X &&
                    load_cnt == 6'(X_WORDS - 1);
        last_step = step && count_mul == 3'd7 &&
                    col_idx == 2'd3;
        bus.in_ready = rdy;
    end

    // Registered write bus, load counter, done flags and step counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.wr_en   <= 1'b0;
            bus.wr_sel  <= 1'b0;
            bus.wr_addr <= '0;
            bus.wr_data <= '0;
            load_cnt    <= '0;
            aload_done  <= 1'b0;
            xload_done  <= 1'b0;
            count_mul   <= '0;
            col_idx     <= '0;
            ALU_done    <= 1'b0;
        end else begin
            bus.wr_en <= accept;
            ALU_done  <= last_step;
            if (accept) begin
                bus.wr_sel  <= (state == LOAD_X);
                bus.wr_addr <= load_cnt;
                bus.wr_data <= bus.in_data;
                load_cnt    <= (last_a || last_x) ? 6'd0
                                                  : load_cnt + 6'd1;
            end
            if (last_a) aload_done <= 1'b1;
            if (last_x) xload_done <= 1'b1;
            if (state == IDLE && start_in) begin
                load_cnt   <= '0;
                aload_done <= 1'b0;
                xload_done <= 1'b0;
                count_mul  <= '0;
                col_idx    <= '0;
            end
            if (step) begin
                count_mul <= count_mul + 3'd1;
                if (count_mul == 3'd7) col_idx <= col_idx + 2'd1;
            end
        end
    end

    assign x_rd_addr = {col_idx, count_mul};
    assign a_rd_k    = count_mul;

endmodule

// File: tb/tb_operand_sequencer.sv
// Scoreboard bench for operand_sequencer.
// Stimulus pushes expected writes/steps; a negedge monitor checks them.
module tb_operand_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_in = 1'b0;
    logic       input_load_en = 1'b0;
    logic       ALU_en = 1'b0;
    logic       aload_done, xload_done, ALU_done;
    logic [2:0] count_mul, a_rd_k;
    logic [1:0] col_idx;
    logic [4:0] x_rd_addr;

    operand_sequencer_if #(.DATA_W(8)) bus ();

    operand_sequencer dut (
        .clk           (clk),
        .rst           (rst),
        .start_in      (start_in),
        .input_load_en (input_load_en),
        .ALU_en        (ALU_en),
        .bus           (bus),
        .aload_done    (aload_done),
        .xload_done    (xload_done),
        .count_mul     (count_mul),
        .col_idx       (col_idx),
        .x_rd_addr     (x_rd_addr),
        .a_rd_k        (a_rd_k),
        .ALU_done      (ALU_done)
    );

    always #5 clk = ~clk;

    // {adone, xdone, sel, addr[5:0], data[7:0]}
    logic [16:0] wq[$];
    logic [4:0]  mq[$];
    logic        exp_done = 1'b0;
    int          n_vec = 0;
    int          n_err = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: writes, step addresses and ALU_done pulse
    always @(negedge clk) begin
        logic [16:0] e;
        logic [4:0]  m;
        if (bus.wr_en) begin
            if (wq.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_write: addr %0h data %0h",
                         bus.wr_addr, bus.wr_data);
            end else begin
                e = wq.pop_front();
                chk("write", {15'd0, aload_done, xload_done,
                    bus.wr_sel, bus.wr_addr, bus.wr_data}, {15'd0, e});
            end
        end
        if (ALU_en && mq.size() > 0) begin
            m = mq.pop_front();
            chk("x_rd_addr", {27'd0, x_rd_addr}, {27'd0, m});
            chk("a_rd_k", {29'd0, a_rd_k}, {29'd0, m[2:0]});
        end
        if (ALU_done || exp_done)
            chk("alu_done", {31'd0, ALU_done}, {31'd0, exp_done});
    end

    task automatic reset_check();
        rst = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data = 8'hA5;
        ALU_en = 1'b1;
        input_load_en = 1'b1;
        repeat (2) tick();
        @(negedge clk);
        chk("rst_in_ready", {31'd0, bus.in_ready}, 0);
        chk("rst_wr", {16'd0, bus.wr_en, bus.wr_sel, bus.wr_addr,
            bus.wr_data}, 0);
        chk("rst_done", {29'd0, aload_done, xload_done, ALU_done}, 0);
        chk("rst_cnt", {27'd0, col_idx, count_mul}, 0);
        bus.in_valid = 1'b0;
        ALU_en = 1'b0;
        input_load_en = 1'b0;
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic start_job();
        start_in = 1'b1;
        tick();
        start_in = 1'b0;
    endtask

    task automatic load_all(input bit rnd, input bit start_x);
        int  w = 0;
        bit  v, le;
        while (w < 96) begin
            v  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            le = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            bus.in_valid = v;
            input_load_en = le;
            start_in = start_x && (w == 70);
            if (v && le) begin
                bus.in_data = 8'(w);
                if (w < 64)
                    wq.push_back({(w == 63), 1'b0, 1'b0, 6'(w), 8'(w)});
                else
                    wq.push_back({1'b1, (w == 95), 1'b1,
                                  6'(w - 64), 8'(w)});
                w++;
            end else begin
                bus.in_data = 8'hEE;
            end
            tick();
        end
        bus.in_valid = 1'b0;
        start_in = 1'b0;
        input_load_en = 1'b1;
        @(negedge clk);
        chk("wait_in_ready", {31'd0, bus.in_ready}, 0);
        chk("load_done", {30'd0, aload_done, xload_done}, 3);
        tick();
        input_load_en = 1'b0;
    endtask

    task automatic mul_job(input int stop, input bit start_mul);
        for (int s = 0; s < 32; s++) begin
            if (s == stop) break;
            ALU_en = 1'b1;
            start_in = start_mul && (s == 10);
            mq.push_back(5'(s));
            tick();
            if (s % 8 == 7) begin
                ALU_en = 1'b0;
                start_in = (s == 31);
                exp_done = (s == 31);
                tick();
                start_in = 1'b0;
                exp_done = 1'b0;
                if (s == 31) begin
                    input_load_en = 1'b1;
                    @(negedge clk);
                    chk("idle_after_done", {31'd0, bus.in_ready}, 0);
                    chk("cnt_after_done", {27'd0, col_idx, count_mul}, 0);
                    tick();
                    input_load_en = 1'b0;
                end
            end
        end
        start_in = 1'b0;
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data = 8'h00;
        #3;
        reset_check();

        start_job();
        load_all(1'b0, 1'b0);
        mul_job(32, 1'b0);

        start_job();
        load_all(1'b1, 1'b1);
        mul_job(32, 1'b1);

        start_job();
        load_all(1'b0, 1'b0);
        mul_job(13, 1'b0);
        reset_check();

        start_job();
        load_all(1'b0, 1'b0);
        mul_job(32, 1'b0);

        repeat (3) tick();
        chk("wq_empty", wq.size(), 0);
        chk("mq_empty", mq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
